t03_mem_arbiter: RTL and testbench
==================================

T03_MEM_ARBITER -- requirements
Module: t03_mem_arbiter

Interface
REQ-001 SHALL have parameter TIMEOUT_CYCLES, default 255: max cycles waiting for bus_ack before abort (range 1..255).
REQ-002 SHALL have port clk, input, 1: sole clock, rising edge.
REQ-003 SHALL have port nrst, input, 1: reset, asynchronous, active-low.
REQ-004 SHALL have port i_req, input, 1: instruction fetch request.
REQ-005 SHALL have port i_addr, input, 32: fetch address (PC next-address output).
REQ-006 SHALL have port d_read, input, 1: data load request.
REQ-007 SHALL have port d_write, input, 1: data store request.
REQ-008 SHALL have port d_addr, input, 32: data address.
REQ-009 SHALL have port d_wdata, input, 32: store data.
REQ-010 SHALL have port d_sel, input, 4: store byte enables.
REQ-011 SHALL have port bus_rdata, input, 32: memory read data.
REQ-012 SHALL have port bus_ack, input, 1: memory completion strobe.
REQ-013 SHALL have port bus_addr, output, 32: latched address to memory.
REQ-014 SHALL have port bus_wdata, output, 32: latched store data.
REQ-015 SHALL have port bus_sel, output, 4: latched byte enables (4'hF on reads).
REQ-016 SHALL have port bus_read, output, 1: memory read strobe.
REQ-017 SHALL have port bus_write, output, 1: memory write strobe.
REQ-018 SHALL have port i_rdata, output, 32: fetched instruction.
REQ-019 SHALL have port i_ack, output, 1: fetch complete, one-cycle pulse.
REQ-020 SHALL have port d_rdata, output, 32: load data.
REQ-021 SHALL have port d_ack, output, 1: data access complete, one-cycle pulse.
REQ-022 SHALL have port err, output, 1: timeout abort, one-cycle pulse concurrent with the ack.
REQ-023 SHALL have port freeze_pc, output, 1: stall to PC freeze input.

Function
REQ-024 SHALL implement states IDLE, FETCH, DATA, RESP.
REQ-025 IDLE: no request -> stay; only i_req -> FETCH; only d_read|d_write -> DATA; both -> grant side not granted last (last_grant flag), fetch wins first after reset.
REQ-026 On grant, SHALL latch address, wdata, sel, and kind (read/write) into bus_* registers; requester inputs ignored until RESP.
REQ-027 d_read and d_write both high SHALL be treated as write.
REQ-028 bus_read/bus_write SHALL be registered, high for every cycle in FETCH/DATA, low in IDLE and RESP.
REQ-029 In FETCH/DATA, bus_ack=1 at an edge SHALL move to RESP and register bus_rdata into i_rdata (FETCH) or d_rdata (DATA read); d_rdata unchanged on write.
REQ-030 RESP SHALL last exactly one cycle asserting i_ack or d_ack, then IDLE; no grant from RESP.
REQ-031 Minimum latency: request in cycle 0, strobe cycle 1, bus_ack cycle 1, ack cycle 2.
REQ-032 8-bit wait counter SHALL clear on grant, increment each FETCH/DATA cycle without bus_ack; reaching TIMEOUT_CYCLES SHALL go to RESP with err=1, targeted rdata=0.
REQ-033 bus_ack and timeout at same edge: bus_ack wins, err=0.
REQ-034 bus_ack in IDLE or RESP SHALL be ignored.
REQ-035 freeze_pc (combinational) SHALL be 1 in FETCH, DATA, and IDLE when any request is high; 0 in RESP and idle-with-no-request.
REQ-036 last_grant SHALL update at each grant, not on timeout.

Reset
REQ-037 nrst low SHALL immediately force IDLE, all outputs 0, bus_sel 0, counter 0, last_grant=data (so fetch wins next tie), regardless of state.
REQ-038 Reset mid-transaction SHALL drop strobes at once; no ack/err after release for the aborted access.

Verification
REQ-039 i_req, i_addr=0x100, bus_ack cycle 1, bus_rdata=0x00500093 -> bus_read cycles 1, i_ack and i_rdata=0x00500093 cycle 2, freeze_pc 1 cycles 0-1, 0 cycle 2.
REQ-040 i_req and d_write (addr 0x2000, data 0xDEADBEEF, sel 0x3) together after reset -> fetch first; then bus_write, bus_addr=0x2000, bus_sel=0x3; next tie goes to fetch again.
REQ-041 d_read with no bus_ack, TIMEOUT_CYCLES=4 -> after 4 strobe cycles RESP: d_ack=1, err=1, d_rdata=0, bus_read falls.
REQ-042 bus_ack coincident with final timeout cycle -> d_ack=1, err=0, data captured.
REQ-043 nrst low during DATA with bus_write high -> bus_write 0 immediately, state IDLE, no d_ack after release.
REQ-044 d_read and d_write both high, d_addr=0x40 -> bus_write=1, bus_read=0, d_ack after bus_ack, d_rdata unchanged.

Source files
------------

// File: rtl/t03_mem_arbiter.sv
// rtl/t03_mem_arbiter.sv - fetch/data arbiter onto a single memory bus
// Alternates on simultaneous requests, aborts a bus access that waits too long for bus_ack.
module t03_mem_arbiter #(
  parameter int unsigned TIMEOUT_CYCLES = 255
) (
  input  logic        clk,
  input  logic        nrst,
  input  logic        i_req,
  input  logic [31:0] i_addr,
  input  logic        d_read,
  input  logic        d_write,
  input  logic [31:0] d_addr,
  input  logic [31:0] d_wdata,
  input  logic [3:0]  d_sel,
  input  logic [31:0] bus_rdata,
  input  logic        bus_ack,
  output logic [31:0] bus_addr,
  output logic [31:0] bus_wdata,
  output logic [3:0]  bus_sel,
  output logic        bus_read,
  output logic        bus_write,
  output logic [31:0] i_rdata,
  output logic        i_ack,
  output logic [31:0] d_rdata,
  output logic        d_ack,
  output logic        err,
  output logic        freeze_pc
);

  typedef enum logic [1:0] {S_IDLE, S_FETCH, S_DATA, S_RESP} state_t;

  localparam logic [7:0] LP_LAST_WAIT = 8'(TIMEOUT_CYCLES - 1);

  state_t     r_state;
  logic [7:0] r_wait;
  logic       r_last_data;

  logic w_dreq;
  logic w_pick_fetch;

  assign w_dreq       = d_read | d_write;
  // On a tie, fetch wins unless the previous grant already went to fetch.
  assign w_pick_fetch = i_req & (~w_dreq | r_last_data);

  assign freeze_pc = nrst & ((r_state == S_FETCH) | (r_state == S_DATA) |
                             ((r_state == S_IDLE) & (i_req | w_dreq)));

  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) begin
      r_state     <= S_IDLE;
      r_wait      <= 8'd0;
      r_last_data <= 1'b1;
      bus_addr    <= 32'd0;
      bus_wdata   <= 32'd0;
      bus_sel     <= 4'd0;
      bus_read    <= 1'b0;
      bus_write   <= 1'b0;
      i_rdata     <= 32'd0;
      i_ack       <= 1'b0;
      d_rdata     <= 32'd0;
      d_ack       <= 1'b0;
      err         <= 1'b0;
    end else begin
      i_ack <= 1'b0;
      d_ack <= 1'b0;
      err   <= 1'b0;
      case (r_state)
        S_IDLE: begin
          if (i_req || w_dreq) begin
            r_wait <= 8'd0;
            if (w_pick_fetch) begin
              r_state     <= S_FETCH;
              r_last_data <= 1'b0;
              bus_addr    <= i_addr;
              bus_wdata   <= 32'd0;
              bus_sel     <= 4'hF;
              bus_read    <= 1'b1;
              bus_write   <= 1'b0;
            end else begin
              r_state     <= S_DATA;
              r_last_data <= 1'b1;
              bus_addr    <= d_addr;
              bus_wdata   <= d_wdata;
              bus_sel     <= d_write ? d_sel : 4'hF;
              bus_read    <= ~d_write;
              bus_write   <= d_write;
            end
          end
        end
        S_FETCH, S_DATA: begin
          if (bus_ack || (r_wait == LP_LAST_WAIT)) begin
            r_state   <= S_RESP;
            bus_read  <= 1'b0;
            bus_write <= 1'b0;
            err       <= ~bus_ack;
            if (r_state == S_FETCH) begin
              i_ack   <= 1'b1;
              i_rdata <= bus_ack ? bus_rdata : 32'd0;
            end else begin
              d_ack <= 1'b1;
              if (bus_read) begin
                d_rdata <= bus_ack ? bus_rdata : 32'd0;
              end
            end
          end else begin
            r_wait <= r_wait + 8'd1;
          end
        end
        default: begin
          r_state <= S_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_t03_mem_arbiter.sv
// tb/tb_t03_mem_arbiter.sv - directed and randomized check of t03_mem_arbiter
// Reference model works per transaction: grant choice, strobe count and response data.
module tb_t03_mem_arbiter;

  localparam int T = 4;

  logic        clk;
  logic        nrst;
  logic        i_req;
  logic [31:0] i_addr;
  logic        d_read;
  logic        d_write;
  logic [31:0] d_addr;
  logic [31:0] d_wdata;
  logic [3:0]  d_sel;
  logic [31:0] bus_rdata;
  logic        bus_ack;
  logic [31:0] bus_addr;
  logic [31:0] bus_wdata;
  logic [3:0]  bus_sel;
  logic        bus_read;
  logic        bus_write;
  logic [31:0] i_rdata;
  logic        i_ack;
  logic [31:0] d_rdata;
  logic        d_ack;
  logic        err;
  logic        freeze_pc;

  int vectors;
  int miscompares;

  logic        m_last_data;
  logic [31:0] m_irdata;
  logic [31:0] m_drdata;

  t03_mem_arbiter #(.TIMEOUT_CYCLES(T)) dut (
    .clk(clk), .nrst(nrst),
    .i_req(i_req), .i_addr(i_addr),
    .d_read(d_read), .d_write(d_write), .d_addr(d_addr),
    .d_wdata(d_wdata), .d_sel(d_sel),
    .bus_rdata(bus_rdata), .bus_ack(bus_ack),
    .bus_addr(bus_addr), .bus_wdata(bus_wdata), .bus_sel(bus_sel),
    .bus_read(bus_read), .bus_write(bus_write),
    .i_rdata(i_rdata), .i_ack(i_ack),
    .d_rdata(d_rdata), .d_ack(d_ack),
    .err(err), .freeze_pc(freeze_pc)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    vectors++;
    assert (got === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %h expected %h", tag, got, exp);
    end
  endtask

  task automatic model_reset();
    m_last_data = 1'b1;
    m_irdata    = 32'd0;
    m_drdata    = 32'd0;
  endtask

  // One complete transaction starting in IDLE; delay = cycles of waiting before bus_ack.
  task automatic do_txn(input logic rq_i, input logic rq_r, input logic rq_w,
                        input logic [31:0] ia, input logic [31:0] da,
                        input logic [31:0] wd, input logic [3:0] sel,
                        input int delay, input logic [31:0] rd);
    logic        exp_fetch;
    logic        exp_write;
    logic [31:0] exp_addr;
    logic [3:0]  exp_sel;
    int          n_strobe;
    logic        timeout;

    exp_fetch = rq_i && (!(rq_r || rq_w) || m_last_data);
    exp_write = !exp_fetch && rq_w;
    exp_addr  = exp_fetch ? ia : da;
    exp_sel   = exp_write ? sel : 4'hF;
    timeout   = (delay >= T);
    n_strobe  = timeout ? T : delay + 1;
    m_last_data = !exp_fetch;

    i_req = rq_i; d_read = rq_r; d_write = rq_w;
    i_addr = ia; d_addr = da; d_wdata = wd; d_sel = sel;
    bus_ack = 1'($urandom_range(0, 1));
    #1;
    chk("freeze_req", {31'd0, freeze_pc}, 32'd1);
    tick();
    i_req = 1'b0; d_read = 1'b0; d_write = 1'b0;
    i_addr = $urandom; d_addr = $urandom; d_wdata = $urandom; d_sel = 4'($urandom);

    for (int k = 0; k < n_strobe; k++) begin
      bus_ack   = (k == delay);
      bus_rdata = (k == delay) ? rd : $urandom;
      chk("bus_read", {31'd0, bus_read}, {31'd0, !exp_write});
      chk("bus_write", {31'd0, bus_write}, {31'd0, exp_write});
      chk("bus_addr", bus_addr, exp_addr);
      chk("bus_sel", {28'd0, bus_sel}, {28'd0, exp_sel});
      chk("freeze_busy", {31'd0, freeze_pc}, 32'd1);
      chk("ack_early", {30'd0, i_ack, d_ack}, 32'd0);
      if (exp_write) chk("bus_wdata", bus_wdata, wd);
      tick();
    end

    if (exp_fetch) m_irdata = timeout ? 32'd0 : rd;
    else if (!exp_write) m_drdata = timeout ? 32'd0 : rd;

    bus_ack = 1'($urandom_range(0, 1));
    bus_rdata = $urandom;
    chk("resp_i_ack", {31'd0, i_ack}, {31'd0, exp_fetch});
    chk("resp_d_ack", {31'd0, d_ack}, {31'd0, !exp_fetch});
    chk("resp_err", {31'd0, err}, {31'd0, timeout});
    chk("resp_i_rdata", i_rdata, m_irdata);
    chk("resp_d_rdata", d_rdata, m_drdata);
    chk("resp_strobes", {30'd0, bus_read, bus_write}, 32'd0);
    chk("resp_freeze", {31'd0, freeze_pc}, 32'd0);
    tick();

    bus_ack = 1'($urandom_range(0, 1));
    chk("idle_acks", {29'd0, i_ack, d_ack, err}, 32'd0);
    chk("idle_strobes", {30'd0, bus_read, bus_write}, 32'd0);
    chk("idle_freeze", {31'd0, freeze_pc}, 32'd0);
  endtask

  initial begin
    vectors = 0;
    miscompares = 0;
    nrst = 1'b0;
    i_req = 1'b0; i_addr = 32'd0; d_read = 1'b0; d_write = 1'b0;
    d_addr = 32'd0; d_wdata = 32'd0; d_sel = 4'd0;
    bus_rdata = 32'd0; bus_ack = 1'b0;
    model_reset();
    tick();
    tick();
    chk("rst_bus_addr", bus_addr, 32'd0);
    chk("rst_bus_sel", {28'd0, bus_sel}, 32'd0);
    chk("rst_flags", {26'd0, bus_read, bus_write, i_ack, d_ack, err, freeze_pc}, 32'd0);
    chk("rst_rdata", i_rdata | d_rdata | bus_wdata, 32'd0);
    nrst = 1'b1;
    tick();

    // Tie after reset goes to fetch, the held store follows, the next tie is fetch again.
    do_txn(1, 0, 1, 32'h0000_0200, 32'h0000_2000, 32'hDEAD_BEEF, 4'h3, 0, 32'h1111_2222);
    do_txn(0, 0, 1, 32'h0, 32'h0000_2000, 32'hDEAD_BEEF, 4'h3, 1, 32'h3333_4444);
    do_txn(1, 1, 0, 32'h0000_0204, 32'h0000_3000, 32'h0, 4'h0, 0, 32'h5555_6666);
    do_txn(0, 1, 0, 32'h0, 32'h0000_3000, 32'h0, 4'h0, 2, 32'h7777_8888);

    do_txn(1, 0, 0, 32'h0000_0100, 32'h0, 32'h0, 4'h0, 0, 32'h0050_0093);
    do_txn(0, 1, 0, 32'h0, 32'h0000_4000, 32'h0, 4'h0, 99, 32'hAAAA_AAAA);
    do_txn(0, 1, 0, 32'h0, 32'h0000_4004, 32'h0, 4'h0, T - 1, 32'hCAFE_F00D);
    do_txn(0, 1, 1, 32'h0, 32'h0000_0040, 32'h1234_5678, 4'hC, 1, 32'hBBBB_BBBB);
    do_txn(1, 0, 0, 32'h0000_0108, 32'h0, 32'h0, 4'h0, 7, 32'hCCCC_CCCC);

    // Reset while a store is on the bus.
    d_write = 1'b1; d_addr = 32'h0000_5000; d_wdata = 32'h0F0F_0F0F; d_sel = 4'h5;
    bus_ack = 1'b0;
    tick();
    d_write = 1'b0;
    tick();
    chk("pre_rst_write", {31'd0, bus_write}, 32'd1);
    nrst = 1'b0;
    #1;
    chk("async_rst_strobes", {30'd0, bus_read, bus_write}, 32'd0);
    chk("async_rst_addr", bus_addr, 32'd0);
    chk("async_rst_flags", {28'd0, i_ack, d_ack, err, freeze_pc}, 32'd0);
    model_reset();
    tick();
    nrst = 1'b1;
    for (int k = 0; k < T + 2; k++) begin
      bus_ack = 1'($urandom_range(0, 1));
      tick();
      chk("post_rst_quiet", {27'd0, bus_read, bus_write, i_ack, d_ack, err}, 32'd0);
    end
    bus_ack = 1'b0;
    do_txn(1, 1, 0, 32'h0000_0300, 32'h0000_6000, 32'h0, 4'h0, 0, 32'h9999_0000);

    for (int n = 0; n < 80; n++) begin
      logic ri, rr, rw;
      ri = 1'($urandom_range(0, 1));
      rr = 1'($urandom_range(0, 1));
      rw = 1'($urandom_range(0, 1));
      if (!(ri || rr || rw)) ri = 1'b1;
      do_txn(ri, rr, rw, $urandom, $urandom, $urandom, 4'($urandom),
             int'($urandom_range(0, T + 1)), $urandom);
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
